// File: rtl/i2c_byte_master.sv
// i2c_byte_master
// Byte-level I2C master. Executes one command at a time (START, WRITE byte,
// READ byte, STOP) on open-drain SCL/SDA lines and returns one response per
// command.
//
// Ports
//   tb_clk, tb_rst_n      clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00 START, 01 WRITE, 10 READ, 11 STOP
//   cmd_data              byte to send on WRITE
//   cmd_nack              READ: 1 sends NACK, 0 sends ACK
//   rsp_valid             one-cycle response pulse
//   rsp_data/rsp_nack     READ byte / WRITE ACK bit (1 = NACK)
//   rsp_err               command rejected (bus not owned)
//   busy                  bus owned (after START until STOP completes)
//   scl_oe/sda_oe         1 = pull line low, 0 = release
//   scl_in/sda_in         sampled line levels
//   dbg_state             current FSM state
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is 1 only in IDLE and out of reset.
// cmd_valid while cmd_ready is 0 is ignored, never queued. rsp_valid is a
// single-cycle pulse with no back-pressure; response fields hold their
// values until the next response.
module i2c_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       tb_clk,
  input  logic       tb_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_STOP  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       shift_q, shift_d;
  logic             nack_q, nack_d;
  logic             ack_q, ack_d;
  logic             own_q, own_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_nack_q, rsp_nack_d;
  logic             rsp_err_q, rsp_err_d;

  logic       stall;
  logic       last_cyc;
  logic       step_end;
  logic [2:0] bit_idx;
  logic       tx_bit;

  // Slots 8..1 carry data MSB first; slot 8 maps to index 7 via the wrap.
  assign bit_idx = bit_q[2:0] - 3'd1;
  assign tx_bit  = shift_q[bit_idx];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    op_d       = op_q;
    shift_d    = shift_q;
    nack_d     = nack_q;
    ack_d      = ack_q;
    own_d      = own_q;
    rsp_data_d = rsp_data_q;
    rsp_nack_d = rsp_nack_q;
    rsp_err_d  = rsp_err_q;
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    cmd_ready  = (state_q == S_IDLE) && tb_rst_n;
    rsp_valid  = (state_q == S_RESP);

    // A slave stretching the clock keeps SCL low after we release it in q1;
    // the quarter does not start counting until the line is seen high.
    stall    = (qtr_q == 2'd1) && (cnt_q == '0) && !scl_in;
    last_cyc = (cnt_q == CNT_LAST);
    step_end = last_cyc && (qtr_q == 2'd3);

    case (state_q)
      S_IDLE: begin
        // While owned, keep SCL low between commands.
        scl_oe = own_q;
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          shift_d = cmd_data;
          nack_d  = cmd_nack;
          cnt_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 4'd8;
          if ((cmd_op != OP_START) && !own_q) begin
            state_d    = S_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = 8'h00;
            rsp_nack_d = 1'b0;
          end else begin
            case (cmd_op)
              OP_START: state_d = S_START;
              OP_STOP:  state_d = S_STOP;
              default:  state_d = S_BIT;
            endcase
          end
        end
      end

      S_START: begin
        case (qtr_q)
          2'd0:    scl_oe = own_q;
          2'd2:    sda_oe = 1'b1;
          2'd3:    begin scl_oe = 1'b1; sda_oe = 1'b1; end
          default: ;
        endcase
        if (step_end) begin
          own_d      = 1'b1;
          state_d    = S_RESP;
          rsp_data_d = 8'h00;
          rsp_nack_d = 1'b0;
          rsp_err_d  = 1'b0;
        end
      end

      S_BIT: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        if (bit_q != 4'd0) begin
          sda_oe = (op_q == OP_WRITE) ? !tx_bit : 1'b0;
        end else begin
          sda_oe = (op_q == OP_READ) ? !nack_q : 1'b0;
        end
        if ((qtr_q == 2'd2) && last_cyc) begin
          if (bit_q != 4'd0) begin
            if (op_q == OP_READ) shift_d = {shift_q[6:0], sda_in};
          end else begin
            ack_d = sda_in;
          end
        end
        if (step_end) begin
          if (bit_q == 4'd0) begin
            state_d    = S_RESP;
            rsp_data_d = (op_q == OP_READ) ? shift_q : 8'h00;
            rsp_nack_d = (op_q == OP_WRITE) ? ack_q : 1'b0;
            rsp_err_d  = 1'b0;
          end else begin
            bit_d = bit_q - 4'd1;
          end
        end
      end

      S_STOP: begin
        case (qtr_q)
          2'd0:    begin scl_oe = 1'b1; sda_oe = 1'b1; end
          2'd1:    sda_oe = 1'b1;
          default: ;
        endcase
        if (step_end) begin
          own_d      = 1'b0;
          state_d    = S_RESP;
          rsp_data_d = 8'h00;
          rsp_nack_d = 1'b0;
          rsp_err_d  = 1'b0;
        end
      end

      S_RESP: begin
        scl_oe  = own_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_START) || (state_q == S_BIT) || (state_q == S_STOP)) begin
      if (!stall) begin
        if (last_cyc) begin
          cnt_d = '0;
          qtr_d = qtr_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge tb_clk) begin
    if (!tb_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 4'd0;
      op_q       <= 2'd0;
      shift_q    <= 8'h00;
      nack_q     <= 1'b0;
      ack_q      <= 1'b0;
      own_q      <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_nack_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      op_q       <= op_d;
      shift_q    <= shift_d;
      nack_q     <= nack_d;
      ack_q      <= ack_d;
      own_q      <= own_d;
      rsp_data_q <= rsp_data_d;
      rsp_nack_q <= rsp_nack_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = own_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: drives commands, models an I2C slave on the
// open-drain lines, decodes the bus, and checks every response for timing
// and content against a command-level model.
module tb_i2c_byte_master;

  localparam int D  = 4;
  localparam int EW = 12;  // {op[1:0], err, nack, data[7:0]}

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  // ---------------- clock / reset / DUT ----------------
  logic       tb_clk    = 1'b0;
  logic       tb_rst_n  = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op    = 2'b00;
  logic [7:0] cmd_data  = 8'h00;
  logic       cmd_nack  = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, busy, scl_oe, sda_oe;
  logic [7:0] rsp_data;
  logic [2:0] dbg_state;
  logic       scl_in, sda_in;

  logic stretch_on = 1'b0;
  logic slave_low  = 1'b0;

  assign scl_in = !scl_oe && !stretch_on;
  assign sda_in = !sda_oe && !slave_low;

  always #5 tb_clk = !tb_clk;

  i2c_byte_master #(.CLK_DIV(D)) dut (
    .tb_clk(tb_clk), .tb_rst_n(tb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .rsp_err(rsp_err), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_in), .sda_in(sda_in), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int n     = 0;
  logic [EW-1:0] exp_q[$];
  int due_q[$];
  int acc_q[$];

  bit         own_m = 1'b0;
  bit         rst_at_edge = 1'b0;
  bit         data_active = 1'b0;
  int         bits_seen = 0;
  logic [8:0] cap = '0;
  logic [8:0] last_cap = '0;
  int         last_lat = 0;
  logic [1:0] cur_op = 2'b00;
  logic [7:0] cur_wdata = 8'h00;
  logic [7:0] cur_sbyte = 8'h00;
  logic       cur_ack = 1'b1;
  logic       cur_nack = 1'b0;
  bit         stretch_req = 1'b0;
  int         st_cnt = 0;
  int         starts = 0, stops = 0, starts_snap = 0, stops_snap = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, n);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, n);
  endtask

  // Level the slave puts on SDA for slot index b (number of SCL rises seen).
  function automatic logic drive_for(input int b);
    if ((cur_op == OP_READ) && (b < 8)) return !cur_sbyte[7-b];
    if ((cur_op == OP_WRITE) && (b == 8)) return cur_ack;
    return 1'b0;
  endfunction

  always @(posedge tb_clk) rst_at_edge = tb_rst_n;

  // ---------------- slave, bus monitor and compare process ----------------
  always @(negedge tb_clk) begin
    logic [EW-1:0] e;
    int   due, acc, lat;
    bit   err;
    logic scl_now, sda_now;
    n++;
    scl_now = scl_in;
    sda_now = sda_in;
    if (!tb_rst_n) chk("ready_in_reset", cmd_ready, 0);
    if (!rst_at_edge) begin
      chk("reset_outputs",
          {scl_oe, sda_oe, busy, rsp_valid, rsp_nack, rsp_err, rsp_data}, 0);
      exp_q.delete(); due_q.delete(); acc_q.delete();
      own_m = 1'b0; data_active = 1'b0; slave_low = 1'b0; stretch_on = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (data_active) begin
        if (!prev_scl && scl_now) begin
          cap = {cap[7:0], sda_now};
          bits_seen++;
        end
        if (prev_scl && !scl_now) begin
          slave_low = drive_for(bits_seen);
          if (stretch_req && (cur_op == OP_WRITE) && (bits_seen == 3)) begin
            stretch_on = 1'b1; st_cnt = 0; stretch_req = 1'b0;
          end
        end
      end
      if (prev_scl && scl_now && prev_sda && !sda_now) starts++;
      if (prev_scl && scl_now && !prev_sda && sda_now) stops++;
      // Hold SCL low for 10 clock edges after the master releases it.
      if (stretch_on && !scl_oe) begin
        st_cnt++;
        if (st_cnt > 10) stretch_on = 1'b0;
      end

      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e   = exp_q.pop_front();
          due = due_q.pop_front();
          acc = acc_q.pop_front();
          last_lat = n - acc;
          chk("rsp_cycle", n, due);
          chk("rsp_err", rsp_err, e[9]);
          chk("rsp_nack", rsp_nack, e[8]);
          chk("rsp_data", rsp_data, e[7:0]);
          if (!e[9]) begin
            case (e[11:10])
              OP_START: begin chk("start_cond", starts - starts_snap, 1); own_m = 1'b1; end
              OP_STOP:  begin chk("stop_cond", stops - stops_snap, 1); own_m = 1'b0; end
              OP_WRITE: begin
                chk("wr_bits", bits_seen, 9);
                chk("wr_byte_on_bus", cap[8:1], cur_wdata);
                chk("wr_ack_on_bus", cap[0], !cur_ack);
              end
              default: begin
                chk("rd_bits", bits_seen, 9);
                chk("rd_ack_slot", cap, {cur_sbyte, cur_nack});
              end
            endcase
            chk("no_spurious_cond",
                (e[11:10] == OP_START) ? (stops - stops_snap) : (starts - starts_snap), 0);
          end
          last_cap = cap;
          data_active = 1'b0;
          slave_low = 1'b0;
        end
      end else if ((due_q.size() != 0) && (n > due_q[0])) begin
        timeout_fail("rsp_missing");
        void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(acc_q.pop_front());
        data_active = 1'b0; slave_low = 1'b0;
      end

      chk("busy", busy, own_m);
      if (!own_m && !((exp_q.size() != 0) && (exp_q[0][11:10] == OP_START) && !exp_q[0][9]))
        chk("bus_quiet", {scl_oe, sda_oe}, 0);

      if (cmd_valid && cmd_ready) begin
        err = (cmd_op != OP_START) && !own_m;
        if (err) lat = 1;
        else if ((cmd_op == OP_START) || (cmd_op == OP_STOP)) lat = 4 * D + 1;
        else lat = 36 * D + 1 + ((stretch_req && (cmd_op == OP_WRITE)) ? 10 : 0);
        cur_op    = cmd_op;
        cur_wdata = cmd_data;
        cur_nack  = cmd_nack;
        exp_q.push_back({cmd_op, err,
                         (!err && (cmd_op == OP_WRITE)) ? !cur_ack : 1'b0,
                         (!err && (cmd_op == OP_READ)) ? cur_sbyte : 8'h00});
        due_q.push_back(n + lat);
        acc_q.push_back(n);
        starts_snap = starts;
        stops_snap  = stops;
        if (!err && ((cmd_op == OP_WRITE) || (cmd_op == OP_READ))) begin
          data_active = 1'b1;
          bits_seen = 0;
          cap = '0;
          slave_low = drive_for(0);
        end
      end
      prev_scl = scl_now;
      prev_sda = sda_now;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [1:0] op, input logic [7:0] d, input logic nk);
    int g;
    @(posedge tb_clk); #1;
    cmd_op = op; cmd_data = d; cmd_nack = nk; cmd_valid = 1'b1;
    g = 0;
    do begin
      @(posedge tb_clk);
      g++;
    end while (!cmd_ready && (g < 200));
    #1 cmd_valid = 1'b0;
    if (g >= 200) timeout_fail("cmd_accept");
  endtask

  task automatic wait_rsp();
    int g;
    g = 0;
    while ((exp_q.size() != 0) && (g < 3000)) begin
      @(negedge tb_clk);
      g++;
    end
    if (g >= 3000) timeout_fail("rsp_wait");
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d, input logic nk);
    offer(op, d, nk);
    wait_rsp();
    repeat ($urandom_range(0, 3)) @(posedge tb_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;
    int g;
    tb_rst_n = 1'b0;
    repeat (4) @(posedge tb_clk);
    #1 tb_rst_n = 1'b1;

    // WRITE without START: rejected, no bus activity.
    send(OP_WRITE, 8'h55, 1'b0);
    chk("err_latency", last_lat, 1);
    chk("err_flag", rsp_err, 1);

    send(OP_START, 8'h00, 1'b0);
    chk("start_latency", last_lat, 17);
    chk("busy_after_start", busy, 1);

    cur_ack = 1'b1;
    send(OP_WRITE, 8'hA5, 1'b0);
    chk("write_latency", last_lat, 145);
    chk("a5_on_bus", last_cap, 9'h14A);
    chk("a5_acked", rsp_nack, 0);

    cur_sbyte = 8'h3C;
    send(OP_READ, 8'h00, 1'b1);
    chk("read_3c", rsp_data, 8'h3C);
    chk("read_nack_slot", last_cap, 9'h079);

    cur_ack = 1'b0;
    send(OP_WRITE, 8'($urandom_range(0, 255)), 1'b0);
    chk("nack_seen", rsp_nack, 1);
    chk("busy_after_nack", busy, 1);

    cur_ack = 1'b1;
    stretch_req = 1'b1;
    send(OP_WRITE, 8'($urandom_range(0, 255)), 1'b0);
    chk("stretch_latency", last_lat, 155);

    send(OP_START, 8'h00, 1'b0);
    chk("rstart_latency", last_lat, 17);

    for (int i = 0; i < 8; i++) begin
      cur_ack   = 1'($urandom_range(0, 1));
      cur_sbyte = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) send(OP_WRITE, 8'($urandom_range(0, 255)), 1'b0);
      else send(OP_READ, 8'h00, 1'($urandom_range(0, 1)));
    end

    send(OP_STOP, 8'h00, 1'b0);
    chk("stop_latency", last_lat, 17);
    chk("busy_after_stop", busy, 0);
    send(OP_STOP, 8'h00, 1'b0);
    chk("stop_unowned_err", rsp_err, 1);
    send(OP_READ, 8'h00, 1'b0);
    chk("read_unowned_err", rsp_err, 1);

    // Reset in the middle of a READ (around bit slot 3).
    send(OP_START, 8'h00, 1'b0);
    rb = 8'($urandom_range(0, 255));
    cur_sbyte = rb;
    offer(OP_READ, 8'h00, 1'b0);
    g = 0;
    while ((bits_seen < 5) && (g < 2000)) begin
      @(negedge tb_clk);
      g++;
    end
    if (g >= 2000) timeout_fail("reach_bit3");
    repeat (2 * D) @(posedge tb_clk);
    #1 tb_rst_n = 1'b0;
    @(posedge tb_clk);
    #1 tb_rst_n = 1'b1;
    repeat (6) @(negedge tb_clk);
    chk("busy_after_reset", busy, 0);
    chk("lines_after_reset", {scl_oe, sda_oe}, 0);

    send(OP_START, 8'h00, 1'b0);
    chk("start_after_reset", last_lat, 17);
    cur_ack = 1'b1;
    send(OP_WRITE, 8'($urandom_range(0, 255)), 1'b0);
    send(OP_STOP, 8'h00, 1'b0);

    repeat (4) @(posedge tb_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
